nest_array: RTL and testbench

Parametrised successor to the single static nest: holds up to `N_NESTS` nest positions, loaded sequentially during setup. It answers render and collision queries against all loaded nests with lowest-index priority and reports which nest was hit. During simulation it accumulates a per-nest food count from ant deposit requests, with a one-cycle acknowledge. It sits beside the ant/food objects on the setup and simulation buses.

---
 rtl/nest_array_pkg.sv | 20 ++
 rtl/collision_square.sv | 31 +++
 rtl/nest_prio_enc.sv | 22 ++
 rtl/nest_array.sv | 179 +++++++++++++++++
 tb/tb_nest_array.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nest_array_pkg.sv
// Shared world parameters for the nest objects and helpers for index widths.
package nest_array_pkg;

   // Screen coordinate widths shared with the ant and food objects
   localparam int X_bits        = 10;
   localparam int Y_bits        = 10;

   // Half-width of a nest's square footprint, in pixels
   localparam int NEST_RADIUS   = 4;

   // Upper bound on nest slots and default food counter width
   localparam int MAX_NESTS     = 16;
   localparam int NEST_CNT_BITS = 16;

   // Width of an index into n slots, never narrower than one bit
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/collision_square.sv
// Square hit test: a point is inside when both axis distances are within RADIUS.
module collision_square
   import nest_array_pkg::*;
#(
   parameter int XW     = X_bits,
   parameter int YW     = Y_bits,
   parameter int RADIUS = NEST_RADIUS
) (
   input  logic          i_valid,
   input  logic [XW-1:0] i_px,
   input  logic [YW-1:0] i_py,
   input  logic [XW-1:0] i_x,
   input  logic [YW-1:0] i_y,
   output logic          o_hit
);

   // Radius widened by one bit so large radii cannot truncate
   localparam logic [XW:0] C_RX = (XW+1)'(RADIUS);
   localparam logic [YW:0] C_RY = (YW+1)'(RADIUS);

   logic [XW-1:0] w_dx;
   logic [YW-1:0] w_dy;

   // Unsigned absolute distances, subtracting the smaller from the larger so nothing wraps
   always_comb begin
      w_dx  = (i_px >= i_x) ? (i_px - i_x) : (i_x - i_px);
      w_dy  = (i_py >= i_y) ? (i_py - i_y) : (i_y - i_py);
      o_hit = i_valid && ({1'b0, w_dx} <= C_RX) && ({1'b0, w_dy} <= C_RY);
   end

endmodule

// File: rtl/nest_prio_enc.sv
// Lowest-index priority encoder: reports whether any slot hit and which one wins.
module nest_prio_enc #(
   parameter int N       = 4,
   parameter int ID_BITS = 2
) (
   input  logic [N-1:0]       i_hit,
   output logic               o_flag,
   output logic [ID_BITS-1:0] o_id
);

   // Scan from the top down so the lowest hitting index is written last and wins
   always_comb begin
      o_flag = |i_hit;
      o_id   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_hit[k]) begin
            o_id = ID_BITS'(k);
         end
      end
   end

endmodule

// File: rtl/nest_array.sv
// Array of up to N_NESTS nests: sequential setup loading, prioritised render and
// collision queries, and per-nest saturating food counters fed by ant deposits.
module nest_array
   import nest_array_pkg::*;
#(
   parameter int N_NESTS  = 4,
   parameter int RADIUS   = NEST_RADIUS,
   parameter int CNT_BITS = NEST_CNT_BITS,
   parameter int ID_BITS  = id_width(N_NESTS)
) (
   input  logic                         Clk,
   input  logic                         RESET,
   input  logic                         SETUP_PHASE,
   input  logic                         SET,
   input  logic [X_bits-1:0]            in_x,
   input  logic [Y_bits-1:0]            in_y,
   output logic                         setup_full,
   output logic [ID_BITS:0]             loaded,
   input  logic [X_bits-1:0]            render_X,
   input  logic [Y_bits-1:0]            render_Y,
   output logic                         renderNest,
   output logic [ID_BITS-1:0]           render_id,
   input  logic [X_bits-1:0]            collide_x,
   input  logic [Y_bits-1:0]            collide_y,
   output logic                         collision,
   output logic [ID_BITS-1:0]           collide_id,
   input  logic                         deposit,
   output logic                         deposit_ack,
   output logic                         deposit_miss,
   output logic [N_NESTS*X_bits-1:0]    nest_x,
   output logic [N_NESTS*Y_bits-1:0]    nest_y,
   output logic [N_NESTS*CNT_BITS-1:0]  food_count
);

   localparam logic [ID_BITS:0] C_FULL = (ID_BITS+1)'(N_NESTS);

   logic               r_setup_d;
   logic [ID_BITS:0]   r_wr_ptr;
   logic               r_ack;
   logic               r_miss;
   logic [N_NESTS-1:0] r_valid;

   logic               w_entry;
   logic [ID_BITS:0]   w_ptr_eff;
   logic               w_load;
   logic               w_dep_ok;
   logic               w_dep_miss;
   logic [N_NESTS-1:0] w_hit_r;
   logic [N_NESTS-1:0] w_hit_c;
   logic               w_coll;
   logic [ID_BITS-1:0] w_cid;
   logic               w_rend;
   logic [ID_BITS-1:0] w_rid;

   // On the entry cycle the pointer is treated as already cleared, so a SET there lands in slot 0
   assign w_entry    = SETUP_PHASE & ~r_setup_d;
   assign w_ptr_eff  = w_entry ? '0 : r_wr_ptr;
   assign w_load     = SETUP_PHASE & SET & (w_ptr_eff < C_FULL);
   assign w_dep_ok   = ~SETUP_PHASE & deposit & w_coll;
   assign w_dep_miss = ~SETUP_PHASE & deposit & ~w_coll;

   // Setup edge detector, write pointer and the one-cycle deposit response pulses
   always_ff @(posedge Clk or posedge RESET) begin
      if (RESET) begin
         r_setup_d <= 1'b0;
         r_wr_ptr  <= '0;
         r_ack     <= 1'b0;
         r_miss    <= 1'b0;
      end else begin
         r_setup_d <= SETUP_PHASE;
         r_wr_ptr  <= w_load ? (w_ptr_eff + 1'b1) : w_ptr_eff;
         r_ack     <= w_dep_ok;
         r_miss    <= w_dep_miss;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_NESTS; gi++) begin : g_slot
         localparam logic [ID_BITS:0]   C_SLOT = (ID_BITS+1)'(gi);
         localparam logic [ID_BITS-1:0] C_ID   = ID_BITS'(gi);

         logic [X_bits-1:0]   r_x;
         logic [Y_bits-1:0]   r_y;
         logic [CNT_BITS-1:0] r_cnt;
         logic                w_sel;

         assign w_sel = w_load && (w_ptr_eff == C_SLOT);

         // Slot position and valid flag: cleared on setup entry, written when the pointer selects it
         always_ff @(posedge Clk or posedge RESET) begin
            if (RESET) begin
               r_valid[gi] <= 1'b0;
               r_x         <= '0;
               r_y         <= '0;
            end else begin
               if (w_entry) begin
                  r_valid[gi] <= w_sel;
               end else if (w_sel) begin
                  r_valid[gi] <= 1'b1;
               end
               if (w_sel) begin
                  r_x <= in_x;
                  r_y <= in_y;
               end
            end
         end

         // Food counter: cleared on setup entry, saturating increment on an accepted deposit here
         always_ff @(posedge Clk or posedge RESET) begin
            if (RESET) begin
               r_cnt <= '0;
            end else if (w_entry) begin
               r_cnt <= '0;
            end else if (w_dep_ok && (w_cid == C_ID) && (r_cnt != {CNT_BITS{1'b1}})) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         collision_square #(
            .XW     (X_bits),
            .YW     (Y_bits),
            .RADIUS (RADIUS)
         ) u_sq_render (
            .i_valid (r_valid[gi]),
            .i_px    (render_X),
            .i_py    (render_Y),
            .i_x     (r_x),
            .i_y     (r_y),
            .o_hit   (w_hit_r[gi])
         );

         collision_square #(
            .XW     (X_bits),
            .YW     (Y_bits),
            .RADIUS (RADIUS)
         ) u_sq_collide (
            .i_valid (r_valid[gi]),
            .i_px    (collide_x),
            .i_py    (collide_y),
            .i_x     (r_x),
            .i_y     (r_y),
            .o_hit   (w_hit_c[gi])
         );

         assign nest_x[gi*X_bits +: X_bits]       = r_x;
         assign nest_y[gi*Y_bits +: Y_bits]       = r_y;
         assign food_count[gi*CNT_BITS +: CNT_BITS] = r_cnt;
      end
   endgenerate

   nest_prio_enc #(
      .N       (N_NESTS),
      .ID_BITS (ID_BITS)
   ) u_enc_render (
      .i_hit  (w_hit_r),
      .o_flag (w_rend),
      .o_id   (w_rid)
   );

   nest_prio_enc #(
      .N       (N_NESTS),
      .ID_BITS (ID_BITS)
   ) u_enc_collide (
      .i_hit  (w_hit_c),
      .o_flag (w_coll),
      .o_id   (w_cid)
   );

   assign renderNest   = w_rend;
   assign render_id    = w_rid;
   assign collision    = w_coll;
   assign collide_id   = w_cid;
   assign setup_full   = (r_wr_ptr == C_FULL);
   assign loaded       = r_wr_ptr;
   assign deposit_ack  = r_ack;
   assign deposit_miss = r_miss;

endmodule

// File: tb/tb_nest_array.sv
// Scoreboard bench for nest_array: stimulus pushes expected values, monitors pop and compare.
module tb_nest_array;
   import nest_array_pkg::*;

   localparam int N  = 4;
   localparam int CB = 4;
   localparam int IB = 2;

   localparam int K_COLL = 0, K_CID = 1, K_REND = 2, K_RID = 3;
   localparam int K_LOAD = 4, K_FULL = 5, K_FC = 6;
   localparam int P_ACK = 1, P_MISS = 2;

   logic                 clk = 1'b0;
   logic                 RESET = 1'b1;
   logic                 SETUP_PHASE = 1'b0;
   logic                 SET = 1'b0;
   logic [X_bits-1:0]    in_x = '0;
   logic [Y_bits-1:0]    in_y = '0;
   logic                 setup_full;
   logic [IB:0]          loaded;
   logic [X_bits-1:0]    render_X = '0;
   logic [Y_bits-1:0]    render_Y = '0;
   logic                 renderNest;
   logic [IB-1:0]        render_id;
   logic [X_bits-1:0]    collide_x = '0;
   logic [Y_bits-1:0]    collide_y = '0;
   logic                 collision;
   logic [IB-1:0]        collide_id;
   logic                 deposit = 1'b0;
   logic                 deposit_ack;
   logic                 deposit_miss;
   logic [N*X_bits-1:0]  nest_x;
   logic [N*Y_bits-1:0]  nest_y;
   logic [N*CB-1:0]      food_count;

   typedef struct {
      int    kind;
      int    idx;
      int    exp;
      string name;
   } chk_t;

   typedef struct {
      int kind;
      int cyc;
   } pls_t;

   chk_t q_chk[$];
   pls_t q_pulse[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   nest_array #(
      .N_NESTS  (N),
      .RADIUS   (4),
      .CNT_BITS (CB),
      .ID_BITS  (IB)
   ) dut (
      .Clk          (clk),
      .RESET        (RESET),
      .SETUP_PHASE  (SETUP_PHASE),
      .SET          (SET),
      .in_x         (in_x),
      .in_y         (in_y),
      .setup_full   (setup_full),
      .loaded       (loaded),
      .render_X     (render_X),
      .render_Y     (render_Y),
      .renderNest   (renderNest),
      .render_id    (render_id),
      .collide_x    (collide_x),
      .collide_y    (collide_y),
      .collision    (collision),
      .collide_id   (collide_id),
      .deposit      (deposit),
      .deposit_ack  (deposit_ack),
      .deposit_miss (deposit_miss),
      .nest_x       (nest_x),
      .nest_y       (nest_y),
      .food_count   (food_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int field(input int kind, input int idx);
      case (kind)
         K_COLL:  return int'(collision);
         K_CID:   return int'(collide_id);
         K_REND:  return int'(renderNest);
         K_RID:   return int'(render_id);
         K_LOAD:  return int'(loaded);
         K_FULL:  return int'(setup_full);
         default: return int'(food_count[idx*CB +: CB]);
      endcase
   endfunction

   // Level monitor: every queued expectation is compared mid-cycle
   always @(negedge clk) begin
      while (q_chk.size() > 0) begin
         chk_t c;
         int   act;
         c   = q_chk.pop_front();
         act = field(c.kind, c.idx);
         n_checks++;
         if (act == c.exp) begin
            n_pass++;
            $display("[%0d] ok   %s = %0d", cyc, c.name, act);
         end else begin
            $display("[%0d] FAIL %s: got %0d, expected %0d", cyc, c.name, act, c.exp);
         end
      end
   end

   // Pulse monitor: each ack/miss pulse must match the next expected kind and cycle
   always @(negedge clk) begin
      if (!RESET && (deposit_ack || deposit_miss)) begin
         n_checks++;
         if (deposit_ack && deposit_miss) begin
            $display("[%0d] FAIL pulse: got ack and miss together, expected one", cyc);
         end else if (q_pulse.size() == 0) begin
            $display("[%0d] FAIL pulse: got unexpected %s, expected none", cyc,
                     deposit_ack ? "ack" : "miss");
         end else begin
            pls_t p;
            int   k;
            p = q_pulse.pop_front();
            k = deposit_ack ? P_ACK : P_MISS;
            if (k == p.kind && cyc == p.cyc) begin
               n_pass++;
               $display("[%0d] ok   pulse %s", cyc, deposit_ack ? "ack" : "miss");
            end else begin
               $display("[%0d] FAIL pulse: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                        cyc, k, cyc, p.kind, p.cyc);
            end
         end
      end
   end

   task automatic push(input int kind, input int idx, input int exp, input string name);
      chk_t c;
      c.kind = kind; c.idx = idx; c.exp = exp; c.name = name;
      q_chk.push_back(c);
   endtask

   task automatic expect_pulse(input int kind);
      pls_t p;
      p.kind = kind; p.cyc = cyc + 1;
      q_pulse.push_back(p);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input int cx, input int cy, input int rx, input int ry);
      collide_x = X_bits'(cx); collide_y = Y_bits'(cy);
      render_X  = X_bits'(rx); render_Y  = Y_bits'(ry);
   endtask

   task automatic load(input int x, input int y);
      SET = 1'b1; in_x = X_bits'(x); in_y = Y_bits'(y);
   endtask

   initial begin
      // Reset state
      step(); step();
      RESET = 1'b0;
      probe(10, 10, 10, 10);
      push(K_COLL, 0, 0, "reset collision");
      push(K_REND, 0, 0, "reset renderNest");
      push(K_LOAD, 0, 0, "reset loaded");
      push(K_FULL, 0, 0, "reset setup_full");
      for (int k = 0; k < N; k++) push(K_FC, k, 0, $sformatf("reset food%0d", k));
      step();

      // Setup: entry cycle load plus three more, then a fifth that must be ignored
      SETUP_PHASE = 1'b1;
      load(20, 20);  step();
      load(60, 60);  push(K_LOAD, 0, 1, "loaded after 1"); step();
      load(20, 22);  push(K_LOAD, 0, 2, "loaded after 2"); step();
      load(100, 5);  push(K_LOAD, 0, 3, "loaded after 3"); step();
      load(7, 7);    push(K_LOAD, 0, 4, "loaded after 4"); push(K_FULL, 0, 1, "full after 4"); step();
      SET = 1'b0;
      push(K_LOAD, 0, 4, "loaded after 5th ignored");
      push(K_FULL, 0, 1, "full after 5th");

      // Queries in setup; deposit here must be ignored
      probe(21, 21, 100, 6);
      deposit = 1'b1;
      push(K_COLL, 0, 1, "coll (21,21)");
      push(K_CID, 0, 0, "cid (21,21) prio slot0");
      push(K_REND, 0, 1, "rend (100,6)");
      push(K_RID, 0, 3, "rid (100,6)");
      step();
      deposit = 1'b0;
      probe(20, 26, 25, 20);
      push(K_COLL, 0, 1, "coll (20,26) edge");
      push(K_CID, 0, 2, "cid (20,26)");
      push(K_REND, 0, 0, "rend (25,20) outside");
      push(K_RID, 0, 0, "rid (25,20) none");
      step();
      probe(7, 7, 0, 0);
      push(K_COLL, 0, 0, "coll (7,7) ignored slot");
      push(K_CID, 0, 0, "cid (7,7)");
      step();

      // Simulation: three back-to-back deposits on slot 1
      SETUP_PHASE = 1'b0;
      probe(60, 63, 0, 0);
      push(K_COLL, 0, 1, "coll (60,63)");
      push(K_CID, 0, 1, "cid (60,63)");
      push(K_FC, 0, 0, "food0 after setup deposit");
      for (int i = 0; i < 3; i++) begin
         deposit = 1'b1; expect_pulse(P_ACK); step();
      end
      deposit = 1'b0;
      push(K_FC, 1, 3, "food1 after 3");
      step();

      // Missed deposit
      probe(200, 200, 0, 0);
      deposit = 1'b1; expect_pulse(P_MISS); step();
      deposit = 1'b0; step();
      push(K_FC, 0, 0, "food0 after miss");
      push(K_FC, 1, 3, "food1 after miss");
      push(K_FC, 2, 0, "food2 after miss");
      push(K_FC, 3, 0, "food3 after miss");

      // Saturation on slot 0 with 4-bit counters
      probe(21, 21, 0, 0);
      for (int i = 0; i < 17; i++) begin
         deposit = 1'b1; expect_pulse(P_ACK); step();
      end
      deposit = 1'b0;
      push(K_FC, 0, 15, "food0 saturated");
      step();

      // Re-enter setup with a load on the entry cycle; deposit there is ignored
      SETUP_PHASE = 1'b1;
      load(5, 5);
      deposit = 1'b1;
      step();
      SET = 1'b0; deposit = 1'b0;
      probe(60, 60, 5, 5);
      push(K_LOAD, 0, 1, "loaded after re-entry");
      push(K_FULL, 0, 0, "full after re-entry");
      push(K_FC, 0, 0, "food0 cleared");
      push(K_FC, 1, 0, "food1 cleared");
      push(K_COLL, 0, 0, "coll old slot invalid");
      push(K_REND, 0, 1, "rend new slot0");
      push(K_RID, 0, 0, "rid new slot0");
      step();

      // Asynchronous reset mid-deposit: clears before the next edge, pulse dropped
      SETUP_PHASE = 1'b0;
      probe(5, 5, 5, 5);
      deposit = 1'b1;
      #2;
      RESET = 1'b1;
      deposit = 1'b0;
      push(K_COLL, 0, 0, "async reset collision");
      push(K_REND, 0, 0, "async reset renderNest");
      push(K_LOAD, 0, 0, "async reset loaded");
      push(K_FC, 0, 0, "async reset food0");
      step(); step();
      RESET = 1'b0;
      step();

      // Drain with a bound, then every expected pulse must have been seen
      for (int i = 0; i < 20 && (q_chk.size() > 0 || q_pulse.size() > 0); i++) step();
      n_checks++;
      if (q_pulse.size() == 0) n_pass++;
      else $display("FAIL pulse drain: got %0d outstanding, expected 0", q_pulse.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
